// File: rtl/imem_pkg.sv
`timescale 1ns/1ps
// imem_pkg
// Shared types and constants for the instruction-memory responder.
//   NOP_INSTR   : instruction returned for misaligned / out-of-range fetches
//   imem_resp_t : one response record {pc, instr, err}
//   params_ok() : parameter legality, evaluated at elaboration by the top
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } imem_resp_t;

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // LATENCY bounded to 1..4; the FIFO must absorb a full pipeline of
  // results, so it may not be shallower than the read latency.
  function automatic bit params_ok(input int depth_words, input int latency,
                                   input int fifo_depth);
    return is_pow2(depth_words) && (depth_words >= 2) &&
           (latency >= 1) && (latency <= 4) &&
           is_pow2(fifo_depth) && (fifo_depth >= latency);
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
`timescale 1ns/1ps
// imem_resp_fifo
// Synchronous FIFO of imem_resp_t with a registered head output.
//   clk_i, rst_i (async, active-low)
//   flush_i      : empties the FIFO at the next edge (wins over push/pop)
//   push_i, push_data_i : write one entry (dropped only if full without pop)
//   pop_i        : remove the head (ignored when empty)
//   head_valid_o, head_o : registered head entry
//   count_o      : current occupancy
// Occupancy is tracked by a counter, pointers wrap modulo DEPTH.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  imem_resp_t    push_data_i,
  input  logic          pop_i,
  output logic          head_valid_o,
  output imem_resp_t    head_o,
  output logic [CW-1:0] count_o
);

  imem_resp_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          head_valid_reg, head_valid_next;
  imem_resp_t    head_reg, head_next;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop      = pop_i && (count_reg != '0);
    do_push     = push_i && ((count_reg != CW'(DEPTH)) || do_pop);
    rd_ptr_next = do_pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next = do_push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    count_next  = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count_reg - 1'b1;
    end
    // The head register is preloaded with whatever entry sits at the
    // new read pointer. If that slot is being written this very edge
    // (the FIFO was empty or drains to the pushed entry), take the push
    // data, since the array still holds the stale value.
    head_valid_next = (count_next != '0);
    head_next       = '0;
    if (head_valid_next) begin
      if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
        head_next = push_data_i;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
    if (flush_i) begin
      rd_ptr_next     = '0;
      wr_ptr_next     = '0;
      count_next      = '0;
      head_valid_next = 1'b0;
      head_next       = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem[wr_ptr_reg] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_reg       <= '0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      head_valid_reg <= head_valid_next;
      head_reg       <= head_next;
    end
  end

  assign head_valid_o = head_valid_reg;
  assign head_o       = head_reg;
  assign count_o      = count_reg;

endmodule

// File: rtl/imem_responder.sv
`timescale 1ns/1ps
// imem_responder
// Instruction-memory responder for the core fetch port. Accepts one PC per
// cycle, reads a word-addressed array through a LATENCY-stage pipeline and
// returns {pc, instr, err} in request order through a response FIFO.
//   clk_i, rst_i (async, active-low)
//   imem_request_valid_i/pc_i/ready_o    : fetch request handshake
//   imem_response_valid_o/pc_o/instr_o/err_o, imem_response_ready_i
//                                        : response handshake (FIFO head)
//   flush_i                              : drop everything in flight
//   load_en_i/load_addr_i/load_data_i    : preload write port
// Credits (pipeline valids + FIFO count) gate request acceptance so the
// pipeline never has to stall and the FIFO can never overflow.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int AW = $clog2(DEPTH_WORDS),
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int OW = $clog2(FIFO_DEPTH + LATENCY + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          imem_request_valid_i,
  input  logic [31:0]   imem_request_pc_i,
  output logic          imem_request_ready_o,
  output logic          imem_response_valid_o,
  output logic [31:0]   imem_response_pc_o,
  output logic [31:0]   imem_response_instr_o,
  output logic          imem_response_err_o,
  input  logic          imem_response_ready_i,
  input  logic          flush_i,
  input  logic          load_en_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i
);

  if (!params_ok(DEPTH_WORDS, LATENCY, FIFO_DEPTH)) begin : g_param_check
    $error("imem_responder: illegal DEPTH_WORDS/LATENCY/FIFO_DEPTH combination");
  end

  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        rd_data_reg;
  logic               run_reg;
  logic               req_bad, accept, rd_en;
  logic [AW-1:0]      rd_idx;
  logic [LATENCY-1:0] st_valid_reg;
  imem_resp_t         st_data_reg [LATENCY];
  imem_resp_t         st_view [LATENCY];
  logic [CW-1:0]      fifo_count;
  logic [OW-1:0]      outstanding;
  logic               head_valid;
  imem_resp_t         head;

  assign rd_idx  = imem_request_pc_i[2 +: AW];
  assign req_bad = (imem_request_pc_i[1:0] != 2'b00) ||
                   ({1'b0, imem_request_pc_i} >= BYTE_LIMIT);

  always_comb begin
    outstanding = OW'(fifo_count);
    for (int i = 0; i < LATENCY; i++) begin
      outstanding = outstanding + OW'(st_valid_reg[i]);
    end
  end

  // run_reg keeps ready low during reset and rises on the first edge after.
  assign imem_request_ready_o = run_reg && !flush_i &&
                                (outstanding < OW'(FIFO_DEPTH));
  assign accept = imem_request_valid_i && imem_request_ready_o;
  assign rd_en  = accept && !req_bad;

  // Instruction array: no reset, registered read. Both updates are
  // non-blocking, so a same-edge read of the written word sees old data.
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem[load_addr_i] <= load_data_i;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // Stage 0 holds pc/err; its instruction comes from the array output
  // register, replaced by a NOP for faulting fetches.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      st_view[i] = st_data_reg[i];
    end
    st_view[0].instr = st_data_reg[0].err ? NOP_INSTR : rd_data_reg;
  end

  // accept is already low during a flush, so stage 0 empties naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_valid_reg <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        st_data_reg[i] <= '0;
      end
    end else begin
      st_valid_reg[0] <= accept;
      if (accept) begin
        st_data_reg[0] <= '{pc: imem_request_pc_i, instr: 32'h0, err: req_bad};
      end
      for (int i = 1; i < LATENCY; i++) begin
        st_valid_reg[i] <= st_valid_reg[i-1] && !flush_i;
        st_data_reg[i]  <= st_view[i-1];
      end
    end
  end

  imem_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_i       (st_valid_reg[LATENCY-1]),
    .push_data_i  (st_view[LATENCY-1]),
    .pop_i        (imem_response_ready_i),
    .head_valid_o (head_valid),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  assign imem_response_valid_o = head_valid;
  assign imem_response_pc_o    = head.pc;
  assign imem_response_instr_o = head.instr;
  assign imem_response_err_o   = head.err;

endmodule
